// File: rtl/blake2_msg_feeder_if.sv
// rtl/blake2_msg_feeder_if.sv - byte-stream handshake bundle between host source, feeder and BLAKE2 core
interface blake2_msg_feeder_if;
  logic       msg_v_i;
  logic [7:0] msg_i;
  logic       msg_last_i;
  logic       msg_ready_o;
  logic       core_ready_i;
  logic       data_v_o;
  logic [7:0] data_o;
  logic       block_first_o;
  logic       block_last_o;

  modport slave (
    input  msg_v_i, msg_i, msg_last_i, core_ready_i,
    output msg_ready_o, data_v_o, data_o, block_first_o, block_last_o
  );

  modport master (
    output msg_v_i, msg_i, msg_last_i, core_ready_i,
    input  msg_ready_o, data_v_o, data_o, block_first_o, block_last_o
  );
endinterface

// File: rtl/blake2_msg_feeder.sv
// rtl/blake2_msg_feeder.sv - turns a key+message byte stream into zero-padded BLAKE2 blocks with flags and ll
module blake2_msg_feeder #(
  parameter int BB       = 128,
  parameter int BB_CLOG2 = 7
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                start_i,
  input  logic [7:0]          kk_i,
  input  logic [7:0]          nn_i,
  input  logic                empty_i,
  blake2_msg_feeder_if.slave  bus,
  output logic [63:0]         ll_o,
  output logic [7:0]          kk_o,
  output logic [7:0]          nn_o,
  output logic                busy_o,
  output logic                done_o
);
  typedef enum logic [2:0] {IDLE, KEY, KPAD, MSG, PAD, ZBLK, GAP, DONE} state_t;

  localparam logic [BB_CLOG2-1:0] LAST_IDX     = BB_CLOG2'(BB - 1);
  localparam logic [63:0]         KEY_BLOCK_LL = 64'(BB);

  state_t              state, state_next;
  logic [BB_CLOG2-1:0] cnt;
  logic [7:0]          key_cnt;
  logic                first_flag, last_flag;
  logic                take, emit, blk_end, key_done, last_now;
  logic [7:0]          emit_byte;

  assign blk_end  = (cnt == LAST_IDX);
  assign key_done = ((key_cnt + 8'd1) == kk_o);
  assign last_now = last_flag | (take & bus.msg_last_i);
  assign bus.msg_ready_o = bus.core_ready_i & ((state == KEY) | (state == MSG));

  always_comb begin
    state_next = state;
    take       = 1'b0;
    emit       = 1'b0;
    emit_byte  = 8'h00;
    case (state)
      IDLE: begin
        if (start_i) begin
          if (empty_i)             state_next = ZBLK;
          else if (kk_i != 8'd0)   state_next = KEY;
          else                     state_next = MSG;
        end
      end
      KEY: begin
        if (bus.msg_v_i && bus.core_ready_i) begin
          take      = 1'b1;
          emit      = 1'b1;
          emit_byte = bus.msg_i;
          // an early last inside the key is treated as end of key and padded out
          if (bus.msg_last_i)   state_next = PAD;
          else if (key_done)    state_next = KPAD;
        end
      end
      KPAD: begin
        if (bus.core_ready_i) begin
          emit = 1'b1;
          if (blk_end) state_next = GAP;
        end
      end
      MSG: begin
        if (bus.msg_v_i && bus.core_ready_i) begin
          take      = 1'b1;
          emit      = 1'b1;
          emit_byte = bus.msg_i;
          if (bus.msg_last_i)   state_next = blk_end ? DONE : PAD;
          else if (blk_end)     state_next = GAP;
        end
      end
      PAD, ZBLK: begin
        if (bus.core_ready_i) begin
          emit = 1'b1;
          if (blk_end) state_next = DONE;
        end
      end
      // one dead cycle lets the core's ready deassertion reach us after byte 127
      GAP:     state_next = MSG;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state             <= IDLE;
      cnt               <= '0;
      key_cnt           <= 8'd0;
      first_flag        <= 1'b0;
      last_flag         <= 1'b0;
      bus.data_v_o      <= 1'b0;
      bus.data_o        <= 8'h00;
      bus.block_first_o <= 1'b0;
      bus.block_last_o  <= 1'b0;
      ll_o              <= 64'd0;
      kk_o              <= 8'd0;
      nn_o              <= 8'd0;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
    end else begin
      state        <= state_next;
      busy_o       <= (state_next != IDLE);
      done_o       <= (state == DONE);
      bus.data_v_o <= emit;
      bus.data_o   <= emit_byte;
      if (emit) begin
        bus.block_first_o <= first_flag;
        bus.block_last_o  <= last_now;
        cnt               <= cnt + BB_CLOG2'(1);
        if (blk_end) first_flag <= 1'b0;
      end
      if (take && bus.msg_last_i) last_flag <= 1'b1;
      if (state == KEY && take) begin
        key_cnt <= key_cnt + 8'd1;
        if (bus.msg_last_i || key_done) ll_o <= KEY_BLOCK_LL;
      end
      if (state == MSG && take) ll_o <= ll_o + 64'd1;
      if (state == IDLE && start_i) begin
        kk_o       <= kk_i;
        nn_o       <= nn_i;
        ll_o       <= 64'd0;
        cnt        <= '0;
        key_cnt    <= 8'd0;
        first_flag <= 1'b1;
        last_flag  <= empty_i;
      end
    end
  end
endmodule

// File: tb/tb_blake2_msg_feeder.sv
// tb/tb_blake2_msg_feeder.sv - randomized bench for blake2_msg_feeder against a block-level model
module tb_blake2_msg_feeder;
  typedef struct {
    logic [7:0] d;
    bit         first;
    bit         last;
    bit         chk_last;
    bit         fin;
    int         pos;
  } exp_t;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        start = 1'b0;
  logic        empty = 1'b0;
  logic [7:0]  kk = 8'd0;
  logic [7:0]  nn = 8'd0;
  logic [63:0] ll;
  logic [7:0]  kk_out, nn_out;
  logic        busy, done;

  int          checks = 0;
  int          errors = 0;
  int          emitted = 0;
  int          done_seen = 0;
  bit          drop_en = 1'b0;
  bit          ready_rand = 1'b0;
  bit          no_accept_run = 1'b0;
  exp_t        exp_q[$];
  logic [7:0]  stream[$];
  logic [63:0] exp_ll;
  logic [7:0]  exp_kk, exp_nn;
  int          exp_len;

  blake2_msg_feeder_if bus();

  blake2_msg_feeder #(.BB(128), .BB_CLOG2(7)) dut (
    .clk(clk), .nreset(nreset), .start_i(start), .kk_i(kk), .nn_i(nn), .empty_i(empty),
    .bus(bus), .ll_o(ll), .kk_o(kk_out), .nn_o(nn_out), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Expected output = key block (if any) then message, each cut into 128-byte zero-padded blocks.
  task automatic build_model(input int kk_v, input bit empty_v, input int n);
    logic [7:0] flat[$];
    int   carry, fstart;
    exp_t e;
    exp_q.delete();
    flat.delete();
    if (empty_v) begin
      repeat (128) flat.push_back(8'h00);
      carry  = 0;
      exp_ll = 64'd0;
    end else if (kk_v > 0 && n <= kk_v) begin
      for (int i = 0; i < n; i++) flat.push_back(stream[i]);
      while (flat.size() < 128) flat.push_back(8'h00);
      carry  = n - 1;
      exp_ll = 64'd128;
    end else begin
      if (kk_v > 0) begin
        for (int i = 0; i < kk_v; i++) flat.push_back(stream[i]);
        while (flat.size() < 128) flat.push_back(8'h00);
      end
      for (int i = kk_v; i < n; i++) flat.push_back(stream[i]);
      carry = flat.size() - 1;
      while (flat.size() % 128 != 0) flat.push_back(8'h00);
      exp_ll = (kk_v > 0) ? 64'(128 + n - kk_v) : 64'(n);
    end
    fstart  = flat.size() - 128;
    exp_len = flat.size();
    for (int i = 0; i < flat.size(); i++) begin
      e.d        = flat[i];
      e.first    = (i < 128);
      e.last     = (i >= carry);
      e.chk_last = (i >= carry) || (i < fstart);
      e.fin      = (i == flat.size() - 1);
      e.pos      = i % 128;
      exp_q.push_back(e);
    end
  endtask

  // Core side: drops ready after every block end, optionally random stalls otherwise.
  initial begin
    int c;
    int hold;
    c = 0;
    hold = 0;
    bus.core_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      if (!busy) c = 0;
      else if (bus.data_v_o) begin
        if (c == 127) begin
          c = 0;
          hold = drop_en ? 20 : 1 + int'($urandom_range(2));
        end else c++;
      end
      @(posedge clk); #1;
      if (hold > 0) begin
        bus.core_ready_i = 1'b0;
        hold--;
      end else bus.core_ready_i = ready_rand ? ($urandom_range(3) != 0) : 1'b1;
    end
  end

  initial begin
    exp_t e;
    bit prev_ready, after_end, final_prev;
    prev_ready = 1'b0;
    after_end  = 1'b0;
    final_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!nreset) begin
        prev_ready = 1'b0;
        after_end  = 1'b0;
        final_prev = 1'b0;
      end else begin
        chk("done_timing", done, final_prev);
        if (done) done_seen++;
        chk("msg_ready_gated", bus.msg_ready_o & ~bus.core_ready_i, 0);
        if (no_accept_run) chk("zblk_no_msg_ready", bus.msg_ready_o, 0);
        if (bus.data_v_o) begin
          chk("no_byte_in_gap", after_end, 0);
          chk("byte_needs_ready", prev_ready, 1);
          if (exp_q.size() == 0) begin
            chk("unexpected_byte", 1, 0);
            after_end  = 1'b0;
            final_prev = 1'b0;
          end else begin
            e = exp_q.pop_front();
            emitted++;
            chk("data", bus.data_o, e.d);
            chk("block_first", bus.block_first_o, e.first);
            if (e.chk_last) chk("block_last", bus.block_last_o, e.last);
            if (e.fin) begin
              chk("ll_at_final", ll, exp_ll);
              chk("kk_at_final", kk_out, exp_kk);
              chk("nn_at_final", nn_out, exp_nn);
            end
            after_end  = (e.pos == 127);
            final_prev = e.fin;
          end
        end else begin
          after_end  = 1'b0;
          final_prev = 1'b0;
        end
        prev_ready = bus.core_ready_i;
      end
    end
  end

  task automatic run(input int kk_v, input int nn_v, input bit empty_v, input int abort_at, input bit poke);
    int idx, guard, n, d0;
    n = stream.size();
    build_model(kk_v, empty_v, n);
    exp_kk = 8'(kk_v);
    exp_nn = 8'(nn_v);
    no_accept_run = empty_v;
    d0 = done_seen;
    emitted = 0;
    @(posedge clk); #1;
    start = 1'b1; kk = 8'(kk_v); nn = 8'(nn_v); empty = empty_v;
    bus.msg_v_i = 1'b1; bus.msg_i = 8'hee; bus.msg_last_i = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; empty = 1'b0;
    idx = 0;
    guard = 0;
    while (done_seen == d0 && guard < 20000) begin
      if (!empty_v && idx < n && $urandom_range(4) != 0) begin
        bus.msg_v_i = 1'b1; bus.msg_i = stream[idx]; bus.msg_last_i = (idx == n - 1);
      end else if (empty_v) begin
        bus.msg_v_i = 1'($urandom_range(1)); bus.msg_i = 8'($urandom); bus.msg_last_i = 1'b1;
      end else bus.msg_v_i = 1'b0;
      if (poke && guard == 40 && idx < n) begin
        start = 1'b1; kk = 8'($urandom); empty = 1'($urandom_range(1));
      end else begin
        start = 1'b0; empty = 1'b0;
      end
      @(negedge clk); #1;
      if (!empty_v && bus.msg_v_i && bus.msg_ready_o) idx++;
      if (abort_at > 0 && emitted >= abort_at) break;
      @(posedge clk); #1;
      guard++;
    end
    bus.msg_v_i = 1'b0; bus.msg_last_i = 1'b0; start = 1'b0; empty = 1'b0;
    if (abort_at == 0) begin
      chk("run_completes", 64'(done_seen - d0), 1);
      repeat (2) @(posedge clk);
      #1 chk("queue_drained", 64'(exp_q.size()), 0);
    end
  endtask

  task automatic check_reset_values();
    chk("rst_data_v", bus.data_v_o, 0);
    chk("rst_data", bus.data_o, 0);
    chk("rst_first", bus.block_first_o, 0);
    chk("rst_last", bus.block_last_o, 0);
    chk("rst_ll", ll, 0);
    chk("rst_kk", kk_out, 0);
    chk("rst_nn", nn_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_msg_ready", bus.msg_ready_o, 0);
  endtask

  task automatic load_abc();
    stream.delete();
    stream.push_back(8'h61);
    stream.push_back(8'h62);
    stream.push_back(8'h63);
  endtask

  task automatic load_random(input int n);
    stream.delete();
    for (int i = 0; i < n; i++) stream.push_back(8'($urandom));
  endtask

  initial begin
    bus.msg_v_i = 1'b0; bus.msg_i = 8'h00; bus.msg_last_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_reset_values();
    @(posedge clk); #1 nreset = 1'b1;

    load_abc();
    run(0, 64, 0, 0, 0);
    chk("abc_model_len", 64'(exp_len), 128);
    chk("abc_ll", ll, 3);
    chk("abc_nn", nn_out, 64);

    stream.delete();
    run(0, 32, 1, 0, 0);
    chk("zblk_model_len", 64'(exp_len), 128);
    chk("zblk_ll", ll, 0);

    drop_en = 1'b1;
    load_random(256);
    run(0, 64, 0, 0, 0);
    drop_en = 1'b0;
    chk("m256_model_len", 64'(exp_len), 256);
    chk("m256_ll", ll, 256);

    load_random(37);
    run(32, 48, 0, 0, 0);
    chk("key32_model_len", 64'(exp_len), 256);
    chk("key32_ll", ll, 133);
    chk("key32_kk", kk_out, 32);

    load_random(16);
    run(16, 20, 0, 0, 0);
    chk("key16_model_len", 64'(exp_len), 128);
    chk("key16_ll", ll, 128);

    load_random(200);
    run(0, 64, 0, 60, 0);
    @(posedge clk); #1 nreset = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    check_reset_values();
    exp_q.delete();
    @(posedge clk); #1 nreset = 1'b1;

    load_abc();
    run(0, 64, 0, 0, 0);
    chk("abc_again_ll", ll, 3);

    ready_rand = 1'b1;
    for (int r = 0; r < 10; r++) begin
      int kk_r, n_r;
      bit emp;
      emp  = ($urandom_range(7) == 0);
      kk_r = ($urandom_range(1) == 0) ? 0 : 1 + int'($urandom_range(63));
      n_r  = 1 + int'($urandom_range(299));
      if (emp) begin
        stream.delete();
        run(0, 1 + int'($urandom_range(63)), 1, 0, 0);
      end else begin
        load_random(n_r);
        run(kk_r, 1 + int'($urandom_range(63)), 0, 0, 1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/blake2_msg_feeder.md
# blake2_msg_feeder

Host-side transmitter for the BLAKE2 core's byte-serial block interface. Accepts an arbitrary-length message (optionally prefixed by a key) as a valid/ready byte stream. Produces the 128-byte zero-padded block sequence the core consumes, together with the block flags, the final byte count `ll`, and the `kk`/`nn` parameters. Sits between the host/DMA byte source and the `blake2` core.

## Interface
Parameters:
- `BB`, 128, block size in bytes (64 for BLAKE2s).
- `BB_CLOG2`, 7, width of the in-block byte counter.

Ports (reset nreset, synchronous, active-low; clock clk):
- `clk`  in  1  clock.
- `nreset`  in  1  synchronous active-low reset.
- `start_i`  in  1  start pulse; sampled in IDLE only.
- `kk_i`  in  8  key length in bytes (0..64); sampled on `start_i`.
- `nn_i`  in  8  digest length in bytes (1..64); sampled on `start_i`.
- `empty_i`  in  1  qualifies `start_i`: the message is zero-length and unkeyed.
- `msg_v_i`  in  1  input byte valid.
- `msg_i`  in  8  input byte; the first `kk` bytes are key, the rest are message.
- `msg_last_i`  in  1  marks the final byte of the stream (key or message).
- `msg_ready_o`  out  1  byte accepted when `msg_v_i & msg_ready_o`.
- `core_ready_i`  in  1  core can accept bytes (core in wait-data).
- `data_v_o`  out  1  byte to core valid.
- `data_o`  out  8  byte to core.
- `block_first_o`  out  1  current byte belongs to block 0.
- `block_last_o`  out  1  current byte belongs to the final block.
- `ll_o`  out  64  total bytes hashed; 128 is included for a key block.
- `kk_o`, `nn_o`  out  8  latched parameters.
- `busy_o`  out  1  not IDLE.
- `done_o`  out  1  one-cycle pulse after the final byte is emitted.

## Operation
- States:
  - IDLE: `start_i` with `empty_i` goes to ZBLK. `start_i` with `kk_i` != 0 goes to KEY. Otherwise `start_i` goes to MSG.
  - KEY: passes key bytes through. After `kk` bytes, goes to KPAD; if that byte carries `msg_last_i`, goes to PAD instead.
  - KPAD: emits zeros to byte 127, then goes to GAP and on to MSG.
  - MSG: passes bytes through. A byte with `msg_last_i` goes to PAD, or straight to DONE if it is byte 127 of the block. Byte 127 without last goes to GAP.
  - PAD: emits zeros through byte 127, then goes to DONE.
  - ZBLK: emits 128 zero bytes, then goes to DONE.
  - GAP: lasts exactly one cycle, ignores `core_ready_i`, then returns to the caller state.
  - DONE: pulses `done_o` and goes to IDLE.
- `msg_ready_o` = `core_ready_i` & state ∈ {KEY, MSG}. It is 0 in every other state, including GAP.
- Pad and zero bytes are emitted only in cycles where `core_ready_i`=1.
- A 7-bit in-block counter increments on every emitted byte and wraps 127→0 at the block boundary.
- 64-bit `ll` counter:
  - Cleared on start.
  - +1 per accepted message byte.
  - Set to 128 when the key block completes, before message bytes are added.
  - Pad bytes do not count.
  - Wraps modulo 2^64.
- Exact-multiple messages do not get an extra block. The only all-pad final block is ZBLK.
- `block_first_o` = 1 for every byte of block 0.
- `block_last_o` = 0 until the byte carrying `msg_last_i`, then 1 through the end of that block. The core latches the value present on the block's last byte.
- `msg_last_i` arriving in KEY before `kk` bytes is a protocol error: the feeder treats it as end of key and pads.
- `msg_v_i` in non-accepting states is ignored.
- `start_i` while busy is ignored.

## Timing
- Byte accepted (or pad byte generated) in cycle N appears on `data_o`/`data_v_o` in cycle N+1. All outputs are registered.
- The core must deassert `core_ready_i` no later than 1 cycle after seeing byte 127. GAP guarantees no byte is issued while the deassertion propagates.
- `ll_o`, `kk_o`, `nn_o` are valid from the cycle `data_v_o` carries the final byte. They are held until the next `start_i`.
- `done_o` asserts the cycle after the final `data_v_o`.
- Reset values:
  - state IDLE.
  - `data_v_o`=0, `data_o`=0.
  - `block_first_o`=0, `block_last_o`=0.
  - `ll_o`=0, `kk_o`=0, `nn_o`=0.
  - `busy_o`=0, `done_o`=0, `msg_ready_o`=0.
- Reset mid-block returns to IDLE the next cycle with no further `data_v_o`.

## Test plan
- Message "abc", unkeyed, nn=64:
  - Bytes 61 62 63 followed by 125 zeros.
  - `block_first_o`=`block_last_o`=1 on all 128 bytes.
  - `ll_o`=3, `done_o` 1 cycle after byte 127.
- `empty_i` start: 128 zero bytes with both flags high, `ll_o`=0, `msg_ready_o` never high.
- 256-byte message with `core_ready_i` dropping for 20 cycles after each block:
  - 2 blocks and no pad block.
  - Block 0 `block_first_o`=1, `block_last_o`=0; block 1 `block_first_o`=0, `block_last_o`=1.
  - `ll_o`=256; no byte is emitted in GAP or while `core_ready_i`=0.
- kk=32 key with 5-byte message:
  - Block 0 is the 32 key bytes plus 96 zeros, `block_last_o`=0.
  - Block 1 is the 5 bytes plus 123 zeros, `block_last_o`=1.
  - `ll_o`=133.
- kk=16 with `msg_last_i` on key byte 16: a single block, key plus 112 zeros, both flags 1, `ll_o`=128.
- Reset asserted at byte 60 of block 0: outputs return to reset values and state is IDLE. A following "abc" run matches the first scenario.
